// File: rtl/bcd_serial_addsub_if.sv
// Handshake bundle for the serial BCD adder/subtractor.
//   in_valid/in_ready  : operand handshake (op_sub, a, b sampled on accept)
//   out_valid/out_ready: result handshake (sum, cout, err held until taken)
// master = operand source / result consumer, slave = the arithmetic unit.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  op_sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// N-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : bcd_serial_addsub_if.slave (operand in / result out handshakes)
// Subtraction is 10's complement: 9's complement of B plus an initial carry
// of 1. cout is carry-out for add and "no borrow" for subtract. Any input
// digit > 9 sets err and forces sum/cout to zero.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  bcd_serial_addsub_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, res_q, sum_q;
  logic [CW-1:0]   cnt_q;
  logic            sub_q, c_q, err_l_q, cout_q, err_q;

  logic            in_ready, out_valid, accept, last;
  logic            in_err;
  logic [3:0]      bd, dig;
  logic [4:0]      t;
  logic            c_d;
  logic [W-1:0]    res_d;

  assign accept = bus.in_valid & in_ready;
  assign last   = (cnt_q == CW'(DIGITS - 1));

  // Flag any digit > 9 on either operand at accept time.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      in_err = in_err | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
  end

  // Shared digit adder; operands shift right so the current digit sits at [3:0].
  always_comb begin
    bd = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t  = {1'b0, a_q[3:0]} + {1'b0, bd} + {4'd0, c_q};
    if (t > 5'd9) begin
      dig = t[3:0] + 4'd6;  // decimal adjust, wraps mod 16
      c_d = 1'b1;
    end else begin
      dig = t[3:0];
      c_d = 1'b0;
    end
  end

  // Result digits enter from the top; after DIGITS shifts digit 0 is at [3:0].
  generate
    if (DIGITS == 1) begin : g_res1
      assign res_d = dig;
    end else begin : g_resn
      assign res_d = {dig, res_q[W-1:4]};
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      err_l_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          sub_q   <= bus.op_sub;
          c_q     <= bus.op_sub;
          cnt_q   <= '0;
          err_l_q <= in_err;
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          res_q <= res_d;
          // Outputs only change on the transition into DONE.
          if (last) begin
            sum_q  <= err_l_q ? '0 : res_d;
            cout_q <= c_d & ~err_l_q;
            err_q  <= err_l_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
  bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();

  bcd_serial_addsub #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  bcd_serial_addsub #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] last_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One DIGITS=4 operation: accept, check held outputs, latency, result, optional pop.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic [15:0] es, input logic ec, input logic ee,
                     input bit pop, input string tag);
    int n;
    bus4.a = a; bus4.b = b; bus4.op_sub = sub; bus4.in_valid = 1'b1;
    n = 0;
    while (!bus4.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " rdy"}, {31'd0, bus4.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.op_sub = 1'($urandom);
    chk({tag, " hold"}, {16'd0, bus4.sum}, {16'd0, last_sum});
    n = 0;
    while (!bus4.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " lat"}, n, 4);
    chk({tag, " sum"}, {16'd0, bus4.sum}, {16'd0, es});
    chk({tag, " flags"}, {30'd0, bus4.cout, bus4.err}, {30'd0, ec, ee});
    last_sum = es;
    if (pop) begin
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
      chk({tag, " pop"}, {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.op_sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op_sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
    last_sum = 16'h0000;
    #2;
    chk("reset ctl", {28'd0, bus4.in_ready, bus4.out_valid, bus4.cout, bus4.err}, 32'b1000);
    chk("reset sum", {16'd0, bus4.sum}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // out_ready while idle does nothing
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk("idle oready", {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);

    op4(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add carry");
    op4(16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b1, 1'b0, 1'b1, "sub nb");
    op4(16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b0, 1'b0, 1'b1, "sub borrow");
    op4(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, "bad digit");
    op4(16'h0009, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, "after err");
    op4(16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b1, "max add");
    op4(16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, "sub 0-1");

    // Backpressure with in_valid pulses that must be ignored
    op4(16'h0045, 16'h0055, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 6; i++) begin
      bus4.in_valid = 1'(i % 2 == 0);
      bus4.a = 16'h0001; bus4.b = 16'h0001; bus4.op_sub = 1'b0;
      @(posedge clk); #1;
      chk("bp stable", {13'd0, bus4.out_valid, bus4.in_ready, bus4.cout, bus4.sum},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0100});
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk("bp release", {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);

    // Reset in the middle of RUN
    bus4.a = 16'h9999; bus4.b = 16'h0001; bus4.op_sub = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst run ctl", {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);
    chk("rst run sum", {15'd0, bus4.cout, bus4.sum}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_sum = 16'h0000;
    op4(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, "post rst");

    // DIGITS=1 instance
    bus1.a = 4'h7; bus1.b = 4'h5; bus1.op_sub = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    chk("d1 run", {31'd0, bus1.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("d1 add", {25'd0, bus1.out_valid, bus1.cout, bus1.err, bus1.sum},
        {25'd0, 1'b1, 1'b1, 1'b0, 4'h2});
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    bus1.a = 4'h3; bus1.b = 4'h5; bus1.op_sub = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("d1 sub", {25'd0, bus1.out_valid, bus1.cout, bus1.err, bus1.sum},
        {25'd0, 1'b1, 1'b0, 1'b0, 4'h8});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
